// File: rtl/slave_alarm_array.sv
// Array of independent alarm-slave channels. Each channel tracks one alarm line
// through FAST/GRACE engagement until it is caught, times out, or loses the alarm.
module slave_alarm_array #(
   parameter int NUM_CH  = 4,
   parameter int GRACE   = 3,
   parameter int TIMEOUT = 100,
   parameter int CNT_W   = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CH-1:0]                alarm_recv,
   input  logic [NUM_CH-1:0]                caught,
   input  logic [NUM_CH-1:0]                clear,
   output logic [2*NUM_CH-1:0]              state_out,
   output logic [2*NUM_CH-1:0]              cause_out,
   output logic [$clog2(NUM_CH+1)-1:0]      active_cnt,
   output logic                             any_stop
);

   localparam int CW = $clog2(NUM_CH+1);
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'((GRACE > 0) ? GRACE - 1 : 0);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FAST  = 2'b01,
      ST_GRACE = 2'b11,
      ST_STOP  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      CS_NONE    = 2'b00,
      CS_CAUGHT  = 2'b01,
      CS_TIMEOUT = 2'b10,
      CS_LOST    = 2'b11
   } cause_e;

   logic [NUM_CH-1:0] active_vec;
   logic [NUM_CH-1:0] stop_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_e           state_q, state_d;
         cause_e           cause_q, cause_d;
         logic [CNT_W-1:0] t_q, t_d;
         logic [CNT_W-1:0] g_q, g_d;
         logic             timeout_hit;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_q <= ST_IDLE;
               cause_q <= CS_NONE;
               t_q     <= '0;
               g_q     <= '0;
            end else begin
               state_q <= state_d;
               cause_q <= cause_d;
               t_q     <= t_d;
               g_q     <= g_d;
            end
         end

         // t keeps counting across GRACE->FAST so the timeout is measured from FAST entry
         assign timeout_hit = TO_EN && (t_q == T_LAST);

         always_comb begin
            state_d = state_q;
            cause_d = cause_q;
            t_d     = t_q;
            g_d     = g_q;
            if (clear[gi]) begin
               state_d = ST_IDLE;
               cause_d = CS_NONE;
               t_d     = '0;
               g_d     = '0;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (alarm_recv[gi]) begin
                        state_d = ST_FAST;
                        t_d     = '0;
                        g_d     = '0;
                     end
                  end
                  ST_FAST: begin
                     if (caught[gi]) begin
                        state_d = ST_STOP;
                        cause_d = CS_CAUGHT;
                     end else if (timeout_hit) begin
                        state_d = ST_STOP;
                        cause_d = CS_TIMEOUT;
                     end else if (!alarm_recv[gi]) begin
                        if (GRACE == 0) begin
                           state_d = ST_STOP;
                           cause_d = CS_LOST;
                        end else begin
                           state_d = ST_GRACE;
                           g_d     = '0;
                           t_d     = t_q + ONE;
                        end
                     end else begin
                        t_d = t_q + ONE;
                     end
                  end
                  ST_GRACE: begin
                     if (caught[gi]) begin
                        state_d = ST_STOP;
                        cause_d = CS_CAUGHT;
                     end else if (timeout_hit) begin
                        state_d = ST_STOP;
                        cause_d = CS_TIMEOUT;
                     end else if (alarm_recv[gi]) begin
                        state_d = ST_FAST;
                        t_d     = t_q + ONE;
                     end else if (g_q == G_LAST) begin
                        state_d = ST_STOP;
                        cause_d = CS_LOST;
                     end else begin
                        g_d = g_q + ONE;
                        t_d = t_q + ONE;
                     end
                  end
                  ST_STOP: begin
                     state_d = ST_STOP;
                  end
                  default: begin
                     state_d = ST_IDLE;
                     cause_d = CS_NONE;
                     t_d     = '0;
                     g_d     = '0;
                  end
               endcase
            end
         end

         assign state_out[2*gi +: 2] = state_q;
         assign cause_out[2*gi +: 2] = cause_q;
         assign active_vec[gi] = (state_q == ST_FAST) || (state_q == ST_GRACE);
         assign stop_vec[gi]   = (state_q == ST_STOP);
      end
   endgenerate

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         active_cnt = active_cnt + CW'(active_vec[i]);
      end
   end

   assign any_stop = |stop_vec;

endmodule
